// File: rtl/uart_fifo_core.sv
// uart_fifo_core: parametrised UART transceiver with a TX FIFO, RX glitch
// rejection and framing-error detection. All outputs are registered.
// Optional macro UART_PARITY_EN adds one even-parity bit after the payload
// on both TX and RX. Without it, rx_parity_err never pulses.
module uart_fifo_core #(
   parameter int CLKS_PER_BIT = 868,
   parameter int DATA_BITS    = 8,
   parameter int STOP_BITS    = 1,
   parameter int TX_DEPTH     = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rxd,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 rx_frame_err,
   output logic                 rx_parity_err,
   output logic                 txd,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_wr,
   output logic                 tx_full,
   output logic                 tx_ovf,
   output logic                 tx_busy
);

`ifdef UART_PARITY_EN
   localparam logic PAR_EN = 1'b1;
`else
   localparam logic PAR_EN = 1'b0;
`endif

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam int AW = $clog2(TX_DEPTH);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BW-1:0] IDX_LAST  = BW'(DATA_BITS - 1);
   localparam logic          STOP_LAST = (STOP_BITS == 2);
   localparam logic [AW:0]   DEPTH_N   = (AW + 1)'(TX_DEPTH);

   typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH} rx_state_t;

   // ---------------- TX FIFO ----------------
   logic [DATA_BITS-1:0] r_fifo [TX_DEPTH];
   logic [AW-1:0]        r_wr_ptr, r_rd_ptr;
   logic [AW:0]          r_count;
   logic                 r_tx_full, r_tx_ovf;
   logic                 w_push, w_tx_pop;
   logic [AW:0]          w_count_next;

   tx_state_t            r_tx_state;
   logic [CW-1:0]        r_tx_cnt;
   logic [BW-1:0]        r_tx_idx;
   logic                 r_tx_stop;
   logic [DATA_BITS-1:0] r_tx_shift;
   logic                 r_tx_par, r_txd, r_tx_busy;

   // Full is judged on the registered flag, so a same-edge pop never frees a slot for a write.
   assign w_push   = tx_wr && !r_tx_full;
   assign w_tx_pop = (r_count != '0) &&
                     ((r_tx_state == TX_IDLE) ||
                      (r_tx_state == TX_STOP && r_tx_cnt == '0 && r_tx_stop == STOP_LAST));
   assign w_count_next = r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_tx_pop};

   // FIFO storage write port; the array carries no reset so it maps to RAM.
   always_ff @(posedge clk) begin
      if (w_push) r_fifo[r_wr_ptr] <= tx_data;
   end

   // FIFO pointers, occupancy, full flag and overflow pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         r_tx_full <= 1'b0;
         r_tx_ovf  <= 1'b0;
      end else begin
         if (w_push)   r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_tx_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count   <= w_count_next;
         r_tx_full <= (w_count_next == DEPTH_N);
         r_tx_ovf  <= tx_wr && r_tx_full;
      end
   end

   // TX framer: pops a word, then shifts out start, data (LSB first), optional parity, stop bits.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tx_state <= TX_IDLE;
         r_tx_cnt   <= '0;
         r_tx_idx   <= '0;
         r_tx_stop  <= 1'b0;
         r_tx_shift <= '0;
         r_tx_par   <= 1'b0;
         r_txd      <= 1'b1;
         r_tx_busy  <= 1'b0;
      end else begin
         r_tx_busy <= 1'b1;
         case (r_tx_state)
            TX_IDLE: begin
               if (w_tx_pop) begin
                  r_tx_shift <= r_fifo[r_rd_ptr];
                  r_tx_par   <= 1'b0;
                  r_txd      <= 1'b0;
                  r_tx_cnt   <= BIT_LAST;
                  r_tx_state <= TX_START;
               end else begin
                  r_tx_busy <= w_push;
               end
            end
            TX_START, TX_DATA: begin
               if (r_tx_cnt != '0) begin
                  r_tx_cnt <= r_tx_cnt - CW'(1);
               end else begin
                  r_tx_cnt <= BIT_LAST;
                  if (r_tx_state == TX_DATA && r_tx_idx == IDX_LAST) begin
                     r_tx_stop <= 1'b0;
                     if (PAR_EN) begin
                        r_txd      <= r_tx_par;
                        r_tx_state <= TX_PARITY;
                     end else begin
                        r_txd      <= 1'b1;
                        r_tx_state <= TX_STOP;
                     end
                  end else begin
                     // Entering DATA from START resets the bit index; otherwise advance it.
                     r_tx_idx   <= (r_tx_state == TX_START) ? '0 : r_tx_idx + BW'(1);
                     r_txd      <= r_tx_shift[0];
                     r_tx_par   <= r_tx_par ^ r_tx_shift[0];
                     r_tx_shift <= {1'b0, r_tx_shift[DATA_BITS-1:1]};
                     r_tx_state <= TX_DATA;
                  end
               end
            end
            TX_PARITY: begin
               if (r_tx_cnt != '0) begin
                  r_tx_cnt <= r_tx_cnt - CW'(1);
               end else begin
                  r_tx_cnt   <= BIT_LAST;
                  r_txd      <= 1'b1;
                  r_tx_state <= TX_STOP;
               end
            end
            TX_STOP: begin
               if (r_tx_cnt != '0) begin
                  r_tx_cnt <= r_tx_cnt - CW'(1);
               end else if (r_tx_stop != STOP_LAST) begin
                  r_tx_stop <= 1'b1;
                  r_tx_cnt  <= BIT_LAST;
               end else if (w_tx_pop) begin
                  // Next word already queued: straight into its start bit, no idle gap.
                  r_tx_shift <= r_fifo[r_rd_ptr];
                  r_tx_par   <= 1'b0;
                  r_txd      <= 1'b0;
                  r_tx_cnt   <= BIT_LAST;
                  r_tx_state <= TX_START;
               end else begin
                  r_tx_state <= TX_IDLE;
                  r_tx_busy  <= w_push;
               end
            end
            default: r_tx_state <= TX_IDLE;
         endcase
      end
   end

   // ---------------- RX ----------------
   logic                 r_rxd_meta, r_rxd_s;
   rx_state_t            r_rx_state;
   logic [CW-1:0]        r_rx_cnt;
   logic [BW-1:0]        r_rx_idx;
   logic [DATA_BITS-1:0] r_rx_shift, r_rx_data;
   logic                 r_rx_par_bit, r_rx_valid, r_rx_frame_err, r_rx_parity_err;
   logic                 w_rx_perr;

   assign w_rx_perr = PAR_EN && ((^r_rx_shift) != r_rx_par_bit);

   // Two-flop synchroniser for the asynchronous serial input; idles high.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rxd_meta <= 1'b1;
         r_rxd_s    <= 1'b1;
      end else begin
         r_rxd_meta <= rxd;
         r_rxd_s    <= r_rxd_meta;
      end
   end

   // RX deframer: centre-samples each bit, rejects short start glitches, flags framing/parity errors.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rx_state      <= RX_IDLE;
         r_rx_cnt        <= '0;
         r_rx_idx        <= '0;
         r_rx_shift      <= '0;
         r_rx_par_bit    <= 1'b0;
         r_rx_data       <= '0;
         r_rx_valid      <= 1'b0;
         r_rx_frame_err  <= 1'b0;
         r_rx_parity_err <= 1'b0;
      end else begin
         r_rx_valid      <= 1'b0;
         r_rx_frame_err  <= 1'b0;
         r_rx_parity_err <= 1'b0;
         if (r_rx_state != RX_IDLE && r_rx_state != RX_WAIT_HIGH && r_rx_cnt != '0) begin
            r_rx_cnt <= r_rx_cnt - CW'(1);
         end else begin
            case (r_rx_state)
               RX_IDLE: begin
                  if (!r_rxd_s) begin
                     r_rx_cnt   <= HALF_LAST;
                     r_rx_state <= RX_START;
                  end
               end
               RX_START: begin
                  // Line back high at mid start bit: a glitch, drop it silently.
                  r_rx_cnt   <= BIT_LAST;
                  r_rx_idx   <= '0;
                  r_rx_state <= r_rxd_s ? RX_IDLE : RX_DATA;
               end
               RX_DATA: begin
                  r_rx_shift <= {r_rxd_s, r_rx_shift[DATA_BITS-1:1]};
                  r_rx_cnt   <= BIT_LAST;
                  r_rx_idx   <= r_rx_idx + BW'(1);
                  if (r_rx_idx == IDX_LAST) r_rx_state <= PAR_EN ? RX_PARITY : RX_STOP;
               end
               RX_PARITY: begin
                  r_rx_par_bit <= r_rxd_s;
                  r_rx_cnt     <= BIT_LAST;
                  r_rx_state   <= RX_STOP;
               end
               RX_STOP: begin
                  r_rx_parity_err <= w_rx_perr;
                  if (!r_rxd_s) begin
                     r_rx_frame_err <= 1'b1;
                     r_rx_state     <= RX_WAIT_HIGH;
                  end else begin
                     if (!w_rx_perr) begin
                        r_rx_data  <= r_rx_shift;
                        r_rx_valid <= 1'b1;
                     end
                     r_rx_state <= RX_IDLE;
                  end
               end
               RX_WAIT_HIGH: begin
                  // Break or stuck-low line: wait for it to return high before hunting again.
                  if (r_rxd_s) r_rx_state <= RX_IDLE;
               end
               default: r_rx_state <= RX_IDLE;
            endcase
         end
      end
   end

   assign rx_data       = r_rx_data;
   assign rx_valid      = r_rx_valid;
   assign rx_frame_err  = r_rx_frame_err;
   assign rx_parity_err = r_rx_parity_err;
   assign txd           = r_txd;
   assign tx_full       = r_tx_full;
   assign tx_ovf        = r_tx_ovf;
   assign tx_busy       = r_tx_busy;

endmodule

// File: tb/tb_uart_fifo_core.sv
// Bench for uart_fifo_core (CLKS_PER_BIT=16, DATA_BITS=8, STOP_BITS=1, TX_DEPTH=4).
// Honours UART_PARITY_EN when defined. The reference model tracks the FIFO as a
// queue and the transmitter as a frame timer; txd is derived from the frame bit
// index, and received words are matched against a scoreboard queue.
module tb_uart_fifo_core;
   localparam int C     = 16;
   localparam int D     = 8;
   localparam int S     = 1;
   localparam int DEPTH = 4;
`ifdef UART_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   localparam int FRAME = (1 + D + P + S) * C;

   logic         clk = 1'b0;
   logic         rst;
   logic         rxd, rxd_drv, loop_en;
   logic [D-1:0] rx_data, tx_data;
   logic         rx_valid, rx_frame_err, rx_parity_err, txd, tx_wr, tx_full, tx_ovf, tx_busy;

   assign rxd = loop_en ? txd : rxd_drv;

   uart_fifo_core #(.CLKS_PER_BIT(C), .DATA_BITS(D), .STOP_BITS(S), .TX_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .rxd(rxd), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_frame_err(rx_frame_err), .rx_parity_err(rx_parity_err), .txd(txd),
      .tx_data(tx_data), .tx_wr(tx_wr), .tx_full(tx_full), .tx_ovf(tx_ovf), .tx_busy(tx_busy));

   always #5 clk = ~clk;

   int checks = 0, errors = 0;
   int cyc = 0;
   logic [D-1:0] mq[$];        // model of FIFO contents
   int           rem = 0;      // cycles left in the frame being sent
   logic [D-1:0] cur = '0;     // word being sent
   logic         exp_ovf = 1'b0;
   logic [D-1:0] exp_d[$];     // words expected at the receiver
   int           exp_t[$];     // nominal stop-bit-centre cycle, -1 = untimed
   int           valid_seen = 0, ferr_seen = 0, perr_seen = 0, ovf_seen = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One clock: drive inputs, advance the model, then check every output.
   task automatic tick(input logic wr, input logic [D-1:0] d);
      logic full_b, etxd;
      int   el, b;
      tx_wr   = wr;
      tx_data = d;
      @(posedge clk);
      cyc++;
      if (rst) begin
         mq.delete();
         exp_d.delete();
         exp_t.delete();
         rem     = 0;
         exp_ovf = 1'b0;
      end else begin
         full_b  = (mq.size() == DEPTH);
         exp_ovf = wr && full_b;
         if (rem > 0) rem--;
         if (rem == 0 && mq.size() > 0) begin
            cur = mq.pop_front();
            rem = FRAME;
            if (loop_en) begin
               exp_d.push_back(cur);
               exp_t.push_back(cyc + (1 + D + P) * C + C / 2);
            end
         end
         if (wr && !full_b) mq.push_back(d);
      end
      #1;
      if (rem == 0) etxd = 1'b1;
      else begin
         el = FRAME - rem;
         b  = el / C;
         if (b == 0)                      etxd = 1'b0;
         else if (b <= D)                 etxd = cur[b-1];
         else if (P == 1 && b == D + 1)   etxd = ^cur;
         else                             etxd = 1'b1;
      end
      chk("txd", 32'(txd), 32'(etxd));
      chk("tx_busy", 32'(tx_busy), 32'(rem > 0 || mq.size() > 0));
      chk("tx_full", 32'(tx_full), 32'(mq.size() == DEPTH));
      chk("tx_ovf", 32'(tx_ovf), 32'(exp_ovf));
      chk("rx_exclusive", 32'(rx_valid && (rx_frame_err || rx_parity_err)), 32'(0));
`ifndef UART_PARITY_EN
      chk("rx_parity_tied", 32'(rx_parity_err), 32'(0));
`endif
      if (tx_ovf) ovf_seen++;
      if (rx_frame_err) ferr_seen++;
      if (rx_parity_err) perr_seen++;
      if (rx_valid) begin
         valid_seen++;
         chk("rx_expected_avail", 32'(exp_d.size() > 0), 32'(1));
         if (exp_d.size() > 0) begin
            logic [D-1:0] ed;
            int           et;
            ed = exp_d.pop_front();
            et = exp_t.pop_front();
            chk("rx_data", 32'(rx_data), 32'(ed));
            if (et >= 0) chk("rx_timing", 32'(cyc >= et && cyc <= et + 4), 32'(1));
         end
      end
      tx_wr = 1'b0;
   endtask

   // Run until transmitter and receiver scoreboard are both empty, bounded.
   task automatic drain(input int max);
      int n = 0;
      while ((exp_d.size() > 0 || rem > 0 || mq.size() > 0) && n < max) begin
         tick(1'b0, '0);
         n++;
      end
      chk("drain_done", 32'(n < max), 32'(1));
   endtask

   // Bit-bang one frame on rxd (loopback must be off).
   task automatic inject(input logic [D-1:0] w, input logic par, input logic stop_v,
                         input int low_len, input logic expect_ok);
      if (expect_ok) begin
         exp_d.push_back(w);
         exp_t.push_back(-1);
      end
      rxd_drv = 1'b0;
      repeat (C) tick(1'b0, '0);
      for (int i = 0; i < D; i++) begin
         rxd_drv = w[i];
         repeat (C) tick(1'b0, '0);
      end
      if (P == 1) begin
         rxd_drv = par;
         repeat (C) tick(1'b0, '0);
      end
      rxd_drv = stop_v;
      repeat (stop_v ? C : low_len) tick(1'b0, '0);
      rxd_drv = 1'b1;
      repeat (2 * C) tick(1'b0, '0);
   endtask

   initial begin
      int v0, f0, p0, o0;
      logic [D-1:0] rv;
      rst = 1'b1; loop_en = 1'b1; rxd_drv = 1'b1; tx_wr = 1'b0; tx_data = '0;

      // 1: reset held 100 cycles
      repeat (100) tick(1'b0, '0);
      chk("reset_rx_data", 32'(rx_data), 32'(0));
      chk("reset_pulses", 32'(valid_seen + ferr_seen + perr_seen + ovf_seen), 32'(0));
      rst = 1'b0;
      repeat (5) tick(1'b0, '0);

      // 2: single word 0xA5 in loopback
      v0 = valid_seen;
      tick(1'b1, 8'hA5);
      drain(2000);
      chk("t2_rx_data", 32'(rx_data), 32'hA5);
      chk("t2_valid_count", 32'(valid_seen - v0), 32'(1));

      // 3: six back-to-back writes, sixth one overflows
      v0 = valid_seen; o0 = ovf_seen;
      for (int i = 1; i <= 6; i++) tick(1'b1, D'(i));
      chk("t3_ovf_count", 32'(ovf_seen - o0), 32'(1));
      drain(5000);
      chk("t3_valid_count", 32'(valid_seen - v0), 32'(5));
      chk("t3_last_word", 32'(rx_data), 32'h05);
      chk("t3_busy_low", 32'(tx_busy), 32'(0));

      // random writes with random spacing, including occasional bursts into a full FIFO
      for (int n = 0; n < 12; n++) begin
         rv = D'($urandom);
         tick(1'b1, rv);
         repeat ($urandom_range(0, 60)) tick(1'b0, '0);
      end
      drain(20000);

      // 4: glitch rejection, then a clean 0x55
      loop_en = 1'b0;
      v0 = valid_seen; f0 = ferr_seen;
      rxd_drv = 1'b0;
      repeat (4) tick(1'b0, '0);
      rxd_drv = 1'b1;
      repeat (40) tick(1'b0, '0);
      chk("t4_glitch_no_valid", 32'(valid_seen - v0), 32'(0));
      chk("t4_glitch_no_ferr", 32'(ferr_seen - f0), 32'(0));
      inject(8'h55, ^8'h55, 1'b1, 0, 1'b1);
      chk("t4_rx_data", 32'(rx_data), 32'h55);
      chk("t4_valid_count", 32'(valid_seen - v0), 32'(1));

      // 5: framing error with a 40-cycle break, then 0x81
      v0 = valid_seen; f0 = ferr_seen;
      inject(8'h3C, ^8'h3C, 1'b0, 40, 1'b0);
      chk("t5_ferr_count", 32'(ferr_seen - f0), 32'(1));
      chk("t5_no_valid", 32'(valid_seen - v0), 32'(0));
      chk("t5_rx_data_kept", 32'(rx_data), 32'h55);
      inject(8'h81, ^8'h81, 1'b1, 0, 1'b1);
      chk("t5_rx_data", 32'(rx_data), 32'h81);
      chk("t5_valid_count", 32'(valid_seen - v0), 32'(1));

`ifdef UART_PARITY_EN
      // 6: parity bit on the wire and a parity-error frame
      loop_en = 1'b1;
      tick(1'b1, 8'h07);
      drain(2000);
      chk("t6_rx_data", 32'(rx_data), 32'h07);
      loop_en = 1'b0;
      v0 = valid_seen; p0 = perr_seen; f0 = ferr_seen;
      inject(8'h07, 1'b0, 1'b1, 0, 1'b0);
      chk("t6_perr_count", 32'(perr_seen - p0), 32'(1));
      chk("t6_no_valid", 32'(valid_seen - v0), 32'(0));
      chk("t6_no_ferr", 32'(ferr_seen - f0), 32'(0));
      chk("t6_rx_data_kept", 32'(rx_data), 32'h07);
`else
      p0 = perr_seen;
      chk("no_parity_pulses", 32'(p0), 32'(0));
`endif

      // reset in the middle of a transmission
      loop_en = 1'b1;
      v0 = valid_seen;
      tick(1'b1, 8'h3C);
      repeat (50) tick(1'b0, '0);
      rst = 1'b1;
      tick(1'b0, '0);
      chk("rst_mid_txd", 32'(txd), 32'(1));
      chk("rst_mid_busy", 32'(tx_busy), 32'(0));
      rst = 1'b0;
      repeat (200) tick(1'b0, '0);
      chk("rst_mid_no_valid", 32'(valid_seen - v0), 32'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/uart_fifo_core.md
Name: uart_fifo_core

Overview:
Parametrised UART transceiver, successor to the fixed 8N1 rx/tx pair. Adds generic data width, baud divisor and stop-bit count, a TX FIFO with back-pressure, RX glitch rejection and framing-error detection. Sits between the pad-level rxd/txd pins and the calculator datapath, which sees a byte-stream valid/full interface.

Parameters:
CLKS_PER_BIT, 868, clock cycles per bit period; must be >= 4.
DATA_BITS, 8, payload bits per frame (5..9), LSB first.
STOP_BITS, 1, TX stop bits (1 or 2); RX checks only the first.
TX_DEPTH, 4, TX FIFO entries; power of two, >= 2.

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
rxd  input  1  serial in, asynchronous to clk
rx_data  output  DATA_BITS  last good received word
rx_valid  output  1  one-cycle pulse: rx_data updated
rx_frame_err  output  1  one-cycle pulse: stop bit sampled 0
rx_parity_err  output  1  one-cycle pulse: parity mismatch (0 without macro)
txd  output  1  serial out, idle high
tx_data  input  DATA_BITS  word to send
tx_wr  input  1  push tx_data into TX FIFO
tx_full  output  1  TX FIFO full; writes dropped
tx_ovf  output  1  one-cycle pulse: tx_wr while tx_full
tx_busy  output  1  FSM not IDLE or FIFO non-empty

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). All outputs registered.
- Reset values: txd=1, rx_data=0, rx_valid=0, rx_frame_err=0, rx_parity_err=0, tx_full=0, tx_ovf=0, tx_busy=0; FIFO pointers 0. Reset mid-frame abandons frame; txd=1 after the reset edge.
- TX FIFO: write accepted iff tx_wr && !tx_full (full judged before any same-edge pop). Rejected write: no state change, tx_ovf pulses.
- TX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE. Bit counter reloads CLKS_PER_BIT-1 each bit.
- IDLE: FIFO non-empty -> pop, load shifter, txd<=0, go START. tx_wr at edge k into an empty idle core -> txd low from edge k+1.
- DATA: DATA_BITS bits, LSB first. STOP: txd=1 for STOP_BITS*CLKS_PER_BIT cycles; on completion, FIFO non-empty -> go directly to START (no idle gap), else IDLE.
- RX: rxd through 2-flop synchroniser (rxd_s). FSM IDLE -> START -> DATA -> [PARITY] -> STOP -> (WAIT_HIGH) -> IDLE.
- IDLE: rxd_s==0 -> START, wait CLKS_PER_BIT/2 cycles; mid-bit rxd_s==1 -> glitch, return IDLE silently.
- DATA: sample every CLKS_PER_BIT cycles at bit centre, DATA_BITS samples, shift LSB first.
- STOP sample: 1 and no parity error -> rx_data<=word, rx_valid pulse same edge. 0 -> rx_frame_err pulse, rx_data unchanged, go WAIT_HIGH until rxd_s==1 (break handling), then IDLE. Stop OK -> IDLE immediately (accepts back-to-back frames).
- rx_valid, rx_frame_err, rx_parity_err mutually exclusive except parity+frame error together (both pulse, no rx_valid).
- Counter width $clog2(CLKS_PER_BIT); no wrap beyond CLKS_PER_BIT-1.

Optional Feature:
UART_PARITY_EN: defined -> one even-parity bit after DATA on TX (XOR of payload); RX samples it, mismatch -> rx_parity_err pulse at stop sample, rx_data not updated, rx_valid stays 0. Undefined -> no PARITY states, frame = start+data+stop, rx_parity_err tied 0.

Test Plan:
CLKS_PER_BIT=16, DATA_BITS=8, STOP_BITS=1, TX_DEPTH=4, macro off unless stated; rxd looped to txd except 4-5.
1. Reset, hold 100 cycles -> txd=1, tx_busy=0, tx_full=0, no pulses.
2. Write 0xA5 -> txd 16-cycle bits 0,1,0,1,0,0,1,0,1,1; rx_data=0xA5, single rx_valid pulse at stop-bit centre.
3. Six writes 0x01..0x06 on consecutive cycles -> 0x06 dropped with one tx_ovf pulse, tx_full high; 0x01..0x05 received with no idle gap between frames; tx_busy low after last stop bit.
4. rxd low 4 cycles then high -> no rx_valid, no rx_frame_err; following 0x55 frame received correctly.
5. Frame 0x3C with stop bit 0, rxd held low 40 cycles then high -> one rx_frame_err pulse, rx_data keeps 0x55; next frame 0x81 -> rx_valid, rx_data=0x81.
6. UART_PARITY_EN defined: 0x07 sends parity bit 1; injected frame 0x07 with parity 0 -> rx_parity_err pulse, no rx_valid; assert rst mid-TX -> txd=1 next edge, tx_busy=0.
